// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite transform buffer.
//   - orientation codes (`UP/`RIGHT/`DOWN/`LEFT), also usable by benches and loaders
//   - pixel struct macro, CW-parameterised so each module can build its own width
//   - state_t for the buffer FSM
`ifndef SPRITE_CONSTANTS_SV
`define SPRITE_CONSTANTS_SV
`define UP    2'd0
`define RIGHT 2'd1
`define DOWN  2'd2
`define LEFT  2'd3
`define SPRITE_PIXEL_T(W) struct packed { logic [(W)-1:0] r; logic [(W)-1:0] g; logic [(W)-1:0] b; }
`endif

package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int PIXEL_CW = 8;

    typedef `SPRITE_PIXEL_T(PIXEL_CW) pixel_t;

endpackage

// File: rtl/sprite_addr_map.sv
// Combinational mapping from output raster position (a = outer, b = inner)
// to the storage address of the source pixel, for a given rotation and
// optional horizontal mirror.
// Ports:
//   i_a, i_b   output position counters
//   i_ori      orientation code (`UP/`RIGHT/`DOWN/`LEFT)
//   i_mir      mirror the output horizontally
//   o_addr     source address = row*DIM + col
module sprite_addr_map #(
    parameter int DIM = 8
) (
    input  logic [$clog2(DIM)-1:0]     i_a,
    input  logic [$clog2(DIM)-1:0]     i_b,
    input  logic [1:0]                 i_ori,
    input  logic                       i_mir,
    output logic [2*$clog2(DIM)-1:0]   o_addr
);
    localparam int AW = $clog2(DIM);
    localparam logic [AW-1:0] N = AW'(DIM - 1);

    logic [AW-1:0] w_bp;
    logic [AW-1:0] w_row;
    logic [AW-1:0] w_col;

    always_comb begin
        w_bp  = i_mir ? (N - i_b) : i_b;
        w_row = i_a;
        w_col = w_bp;
        case (i_ori)
            `UP:    begin w_row = i_a;         w_col = w_bp;      end
            `RIGHT: begin w_row = N - w_bp;    w_col = i_a;       end
            `DOWN:  begin w_row = N - i_a;     w_col = N - w_bp;  end
            default: begin w_row = w_bp;       w_col = N - i_a;   end
        endcase
    end

    // DIM is a power of two, so row*DIM + col is a plain concatenation.
    assign o_addr = {w_row, w_col};

endmodule

// File: rtl/sprite_xform_buffer.sv
// Single-sprite buffer: loads DIM x DIM RGB pixels in raster order and
// streams them back rotated/mirrored, flagging pixels equal to KEY.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start_write, start_read    start pulses, honoured only in IDLE
//   orientation, mirror        read transform, latched on accepted start_read
//   i_valid/i_ready, i_r/g/b   input pixel stream
//   o_valid/o_ready, o_r/g/b   output pixel stream
//   o_transparent, o_last      output pixel equals KEY / final pixel
//   busy, done                 not IDLE / pulse after the final beat
//
// state | meaning
// IDLE  | waiting for start_write (priority) or start_read
// WRITE | accepting input pixels into storage at ptr
// READ  | presenting mapped pixel, advancing on o_ready
module sprite_xform_buffer
    import sprite_pkg::*;
#(
    parameter int               DIM = 8,
    parameter int               CW  = 8,
    parameter logic [3*CW-1:0]  KEY = {3*CW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_write,
    input  logic          start_read,
    input  logic [1:0]    orientation,
    input  logic          mirror,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [CW-1:0] i_r,
    input  logic [CW-1:0] i_g,
    input  logic [CW-1:0] i_b,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [CW-1:0] o_r,
    output logic [CW-1:0] o_g,
    output logic [CW-1:0] o_b,
    output logic          o_transparent,
    output logic          o_last,
    output logic          busy,
    output logic          done
);
    localparam int AW = $clog2(DIM);
    localparam int PW = 2 * AW;
    localparam logic [PW-1:0] PTR_LAST = PW'(DIM * DIM - 1);
    localparam logic [AW-1:0] B_LAST   = AW'(DIM - 1);

    typedef `SPRITE_PIXEL_T(CW) pix_t;

    pix_t          r_mem [DIM*DIM];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [AW-1:0] r_a;
    logic [AW-1:0] r_b;
    logic [1:0]    r_ori;
    logic          r_mir;
    logic          r_done;

    logic          w_wr_beat;
    logic          w_rd_beat;
    logic          w_ptr_last;
    logic [PW-1:0] w_addr;
    pix_t          w_pix;
    pix_t          w_in_pix;

    assign w_wr_beat  = (r_state == WRITE) && i_valid;
    assign w_rd_beat  = (r_state == READ) && o_ready;
    assign w_ptr_last = (r_ptr == PTR_LAST);
    assign w_in_pix   = '{r: i_r, g: i_g, b: i_b};

    sprite_addr_map #(.DIM(DIM)) u_addr_map (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_ori  (r_ori),
        .i_mir  (r_mir),
        .o_addr (w_addr)
    );

    assign w_pix = r_mem[w_addr];

    // State register plus the datapath registers it sequences.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ori   <= `UP;
            r_mir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_wr_beat || w_rd_beat) && w_ptr_last;
            if (r_state == IDLE) begin
                if (start_write) begin
                    r_ptr <= '0;
                end else if (start_read) begin
                    r_ori <= orientation;
                    r_mir <= mirror;
                    r_a   <= '0;
                    r_b   <= '0;
                    r_ptr <= '0;
                end
            end
            // ptr wraps to zero on the final beat, leaving it cleared for the next transfer.
            if (w_wr_beat) begin
                r_ptr <= r_ptr + PW'(1);
            end
            if (w_rd_beat) begin
                r_ptr <= r_ptr + PW'(1);
                r_b   <= r_b + AW'(1);
                if (r_b == B_LAST) begin
                    r_a <= r_a + AW'(1);
                end
            end
        end
    end

    // Storage is never cleared; a beat coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_beat) begin
            r_mem[r_ptr] <= w_in_pix;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_write) begin
                    w_state_nxt = WRITE;
                end else if (start_read) begin
                    w_state_nxt = READ;
                end
            end
            WRITE: begin
                if (w_wr_beat && w_ptr_last) begin
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                if (w_rd_beat && w_ptr_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_ready       = (r_state == WRITE);
        o_valid       = (r_state == READ);
        o_last        = (r_state == READ) && w_ptr_last;
        o_transparent = (r_state == READ) && (w_pix == pix_t'(KEY));
        busy          = (r_state != IDLE);
        done          = r_done;
        o_r           = w_pix.r;
        o_g           = w_pix.g;
        o_b           = w_pix.b;
    end

endmodule

// File: tb/tb_sprite_xform_buffer.sv
module tb_sprite_xform_buffer;

    localparam int DIM = 8;
    localparam int CW  = 8;
    localparam int NPIX = DIM * DIM;
    localparam logic [3*CW-1:0] KEY = {3*CW{1'b1}};

    logic          clk;
    logic          rst_n;
    logic          start_write;
    logic          start_read;
    logic [1:0]    orientation;
    logic          mirror;
    logic          i_valid;
    logic          i_ready;
    logic [CW-1:0] i_r, i_g, i_b;
    logic          o_valid;
    logic          o_ready;
    logic [CW-1:0] o_r, o_g, o_b;
    logic          o_transparent;
    logic          o_last;
    logic          busy;
    logic          done;

    sprite_xform_buffer #(.DIM(DIM), .CW(CW), .KEY(KEY)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_write   (start_write),
        .start_read    (start_read),
        .orientation   (orientation),
        .mirror        (mirror),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_r           (i_r),
        .i_g           (i_g),
        .i_b           (i_b),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_transparent (o_transparent),
        .o_last        (o_last),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3*CW-1:0] pix;
        logic            tr;
        logic            last;
    } exp_t;

    exp_t            sb[$];
    logic [3*CW-1:0] model_mem [NPIX];
    int              total = 0;
    int              bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source pixel index for output beat (a,b), written straight from the mapping table.
    function automatic int src_idx(input logic [1:0] ori, input bit mir, input int a, input int b);
        int n, bp, row, col;
        n  = DIM - 1;
        bp = mir ? n - b : b;
        case (ori)
            `UP:     begin row = a;      col = bp;     end
            `RIGHT:  begin row = n - bp; col = a;      end
            `DOWN:   begin row = n - a;  col = n - bp; end
            default: begin row = bp;     col = n - a;  end
        endcase
        return row * DIM + col;
    endfunction

    // Monitor: pops on every accepted output beat and checks hold-stability during stalls.
    initial begin : monitor
        exp_t            e;
        bit              prev_stall;
        logic [3*CW-1:0] prev_pix;
        logic            prev_last;
        prev_stall = 1'b0;
        prev_pix   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (o_valid && prev_stall) begin
                check("stall_hold_pix", {8'h0, o_r, o_g, o_b}, {8'h0, prev_pix});
                check("stall_hold_last", {31'h0, o_last}, {31'h0, prev_last});
            end
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("out_pix", {8'h0, o_r, o_g, o_b}, {8'h0, e.pix});
                    check("out_transparent", {31'h0, o_transparent}, {31'h0, e.tr});
                    check("out_last", {31'h0, o_last}, {31'h0, e.last});
                end
            end
            prev_stall = o_valid && !o_ready;
            prev_pix   = {o_r, o_g, o_b};
            prev_last  = o_last;
        end
    end

    task automatic do_write(input bit gaps, input bit both, input int key_idx);
        logic [3*CW-1:0] p;
        @(posedge clk); #1;
        start_write = 1'b1;
        start_read  = both;
        @(posedge clk); #1;
        start_write = 1'b0;
        start_read  = 1'b0;
        check("wr_enter_busy", {31'h0, busy}, 32'h1);
        check("wr_enter_i_ready", {31'h0, i_ready}, 32'h1);
        check("wr_enter_no_read", {31'h0, o_valid}, 32'h0);
        for (int idx = 0; idx < NPIX; idx++) begin
            if (gaps && (idx % 3 == 1)) begin
                i_valid = 1'b0;
                @(posedge clk); #1;
            end
            p = (idx == key_idx) ? KEY : {CW'(idx), {CW{1'b0}}, {CW{1'b0}}};
            model_mem[idx] = p;
            {i_r, i_g, i_b} = p;
            i_valid = 1'b1;
            if (idx == 30) start_read = 1'b1;
            check("wr_beat_i_ready", {31'h0, i_ready}, 32'h1);
            @(posedge clk); #1;
            start_read = 1'b0;
            if (idx == 30) check("wr_ignore_start_read", {31'h0, o_valid}, 32'h0);
        end
        i_valid = 1'b0;
        check("wr_done_pulse", {31'h0, done}, 32'h1);
        check("wr_back_idle", {31'h0, busy}, 32'h0);
        check("wr_i_ready_idle", {31'h0, i_ready}, 32'h0);
        @(posedge clk); #1;
        check("wr_done_one_cycle", {31'h0, done}, 32'h0);
        check("wr_no_read_after", {31'h0, o_valid}, 32'h0);
    endtask

    task automatic do_read(input logic [1:0] ori, input bit mir, input bit toggle,
                           input int abort_at, input int exp_cycles);
        int   n_push;
        int   k;
        int   s;
        exp_t e;
        n_push = (abort_at >= 0) ? abort_at + 1 : NPIX;
        for (int i = 0; i < n_push; i++) begin
            s      = src_idx(ori, mir, i / DIM, i % DIM);
            e.pix  = model_mem[s];
            e.tr   = (model_mem[s] == KEY);
            e.last = (i == NPIX - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start_read  = 1'b1;
        orientation = ori;
        mirror      = mir;
        o_ready     = 1'b0;
        @(posedge clk); #1;
        start_read  = 1'b0;
        orientation = ~ori;
        mirror      = ~mir;
        check("rd_first_valid", {31'h0, o_valid}, 32'h1);
        check("rd_busy", {31'h0, busy}, 32'h1);
        k = 0;
        while (k < 400) begin
            o_ready = toggle ? k[0] : 1'b1;
            if (abort_at >= 0 && k == abort_at) rst_n = 1'b0;
            @(posedge clk); #1;
            k++;
            if (!rst_n) break;
            if (done) break;
        end
        o_ready = 1'b0;
        if (abort_at >= 0) begin
            check("rst_o_valid", {31'h0, o_valid}, 32'h0);
            check("rst_o_last", {31'h0, o_last}, 32'h0);
            check("rst_i_ready", {31'h0, i_ready}, 32'h0);
            check("rst_busy", {31'h0, busy}, 32'h0);
            check("rst_done", {31'h0, done}, 32'h0);
            rst_n = 1'b1;
            repeat (3) begin
                @(posedge clk); #1;
                check("rst_no_done", {31'h0, done}, 32'h0);
            end
        end else begin
            check("rd_cycles", 32'(k), 32'(exp_cycles));
            check("rd_end_o_valid", {31'h0, o_valid}, 32'h0);
            check("rd_end_busy", {31'h0, busy}, 32'h0);
            @(posedge clk); #1;
            check("rd_done_one_cycle", {31'h0, done}, 32'h0);
        end
        check("sb_drained", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        start_write = 1'b0;
        start_read  = 1'b0;
        orientation = `UP;
        mirror      = 1'b0;
        i_valid     = 1'b0;
        i_r         = '0;
        i_g         = '0;
        i_b         = '0;
        o_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_i_ready", {31'h0, i_ready}, 32'h0);
        check("reset_o_valid", {31'h0, o_valid}, 32'h0);
        check("reset_o_last", {31'h0, o_last}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;

        do_write(1'b0, 1'b0, -1);
        do_read(`UP,    1'b0, 1'b0, -1, 64);
        do_read(`RIGHT, 1'b0, 1'b0, -1, 64);
        do_read(`DOWN,  1'b0, 1'b0, -1, 64);
        do_read(`LEFT,  1'b0, 1'b0, -1, 64);
        do_read(`UP,    1'b1, 1'b0, -1, 64);
        do_read(`DOWN,  1'b1, 1'b0, -1, 64);
        do_read(`UP,    1'b0, 1'b1, -1, 128);

        do_write(1'b1, 1'b0, -1);
        do_read(`UP,    1'b0, 1'b0, -1, 64);

        do_write(1'b0, 1'b1, 10);
        do_read(`UP,    1'b0, 1'b0, -1, 64);

        do_write(1'b0, 1'b0, -1);
        do_read(`UP,    1'b0, 1'b0, 20, 0);
        do_read(`UP,    1'b0, 1'b0, -1, 64);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
